// File: rtl/pong_game_ctrl_pkg.sv
// Shared codes for the pong rally controller: serve directions, FSM states, winner codes.
package pong_pkg;

  typedef enum logic [1:0] {
    UP_LEFT    = 2'b00,
    DOWN_LEFT  = 2'b01,
    UP_RIGHT   = 2'b10,
    DOWN_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  // Bit 1 selects the horizontal half (1 = toward right), bit 0 the vertical (1 = down).
  function automatic dir_e serve_code(input logic toward_right, input logic down);
    return dir_e'({toward_right, down});
  endfunction

endpackage

// File: rtl/pong_game_ctrl_tick_timer.sv
// Frame-tick down counter; done fires when a tick arrives with the count already at zero.
module tick_timer #(
  parameter int TMR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [TMR_WIDTH-1:0] load_val,
  input  logic                 tick,
  input  logic                 hold,
  output logic                 done
);

  logic [TMR_WIDTH-1:0] count;
  logic                 tick_ok;

  assign tick_ok = tick & ~hold;
  assign done    = tick_ok & (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick_ok && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong rally/score sequencer: serve, play, point and game-over phases driving the ball mover.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int DISP_COLS   = 800,
  parameter int B_WIDTH     = 6,
  parameter int SCORE_WIDTH = 4,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 30,
  parameter int TMR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   pause,
  input  logic [11:0]            ball_center_col,
  output logic                   ball_load,
  output logic [1:0]             serve_dir,
  output logic                   ball_run,
  output logic [SCORE_WIDTH-1:0] l_score,
  output logic [SCORE_WIDTH-1:0] r_score,
  output logic [1:0]             winner,
  output logic [2:0]             state
);

  localparam logic [11:0] LEFT_MISS_COL  = 12'(B_WIDTH / 2 + 1);
  localparam logic [11:0] RIGHT_MISS_COL = 12'(DISP_COLS - 1 - B_WIDTH / 2);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL   = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [TMR_WIDTH-1:0]   SERVE_VAL = TMR_WIDTH'(SERVE_DELAY);
  localparam logic [TMR_WIDTH-1:0]   POINT_VAL = TMR_WIDTH'(POINT_DELAY);

  state_e                 state_q, state_d;
  logic                   start_q;
  logic                   start_edge;
  logic                   toggle_q;
  logic                   conceded_right_q;
  dir_e                   serve_dir_q;
  winner_e                winner_q;

  logic                   timer_load;
  logic [TMR_WIDTH-1:0]   timer_val;
  logic                   timer_hold;
  logic                   timer_done;
  logic                   first_serve;
  logic                   next_serve;
  logic                   miss_left;
  logic                   miss_right;
  logic                   go_over;
  logic                   left_hit;
  logic                   right_hit;

  assign start_edge = start & ~start_q;
  assign left_hit   = (ball_center_col <= LEFT_MISS_COL);
  assign right_hit  = (ball_center_col >= RIGHT_MISS_COL);

  // Timer only runs in the two waiting phases; pause freezes both count and expiry.
  assign timer_hold = pause | ~((state_q == ST_SERVE) | (state_q == ST_POINT));

  tick_timer #(
    .TMR_WIDTH(TMR_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (tick),
    .hold     (timer_hold),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    first_serve = 1'b0;
    next_serve  = 1'b0;
    miss_left   = 1'b0;
    miss_right  = 1'b0;
    go_over     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          timer_load  = 1'b1;
          timer_val   = SERVE_VAL;
          first_serve = 1'b1;
        end
      end
      ST_SERVE: begin
        if (timer_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Left check first so a degenerate overlap of both bounds scores for the right player.
        if (left_hit) begin
          state_d    = ST_POINT;
          timer_load = 1'b1;
          timer_val  = POINT_VAL;
          miss_left  = 1'b1;
        end else if (right_hit) begin
          state_d    = ST_POINT;
          timer_load = 1'b1;
          timer_val  = POINT_VAL;
          miss_right = 1'b1;
        end
      end
      ST_POINT: begin
        if (timer_done) begin
          if ((l_score == WIN_VAL) || (r_score == WIN_VAL)) begin
            state_d = ST_OVER;
            go_over = 1'b1;
          end else begin
            state_d    = ST_SERVE;
            timer_load = 1'b1;
            timer_val  = SERVE_VAL;
            next_serve = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          timer_load  = 1'b1;
          timer_val   = SERVE_VAL;
          first_serve = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_load        <= 1'b0;
      serve_dir_q      <= DOWN_LEFT;
      toggle_q         <= 1'b0;
      conceded_right_q <= 1'b0;
      l_score          <= '0;
      r_score          <= '0;
      winner_q         <= WIN_NONE;
    end else begin
      ball_load <= first_serve | next_serve;
      if (first_serve) begin
        serve_dir_q <= DOWN_LEFT;
        toggle_q    <= 1'b0;
        l_score     <= '0;
        r_score     <= '0;
        winner_q    <= WIN_NONE;
      end
      // Serve goes back toward whoever just conceded; vertical alternates serve to serve.
      if (next_serve) begin
        serve_dir_q <= serve_code(conceded_right_q, toggle_q);
        toggle_q    <= ~toggle_q;
      end
      if (miss_left) begin
        conceded_right_q <= 1'b0;
        if (r_score < WIN_VAL) r_score <= r_score + 1'b1;
      end
      if (miss_right) begin
        conceded_right_q <= 1'b1;
        if (l_score < WIN_VAL) l_score <= l_score + 1'b1;
      end
      if (go_over) begin
        winner_q <= (l_score == WIN_VAL) ? WIN_LEFT : WIN_RIGHT;
      end
    end
  end

  assign ball_run  = (state_q == ST_PLAY) & ~pause;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve timing, misses, pause, win/restart, async reset.
module tb_pong_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        start;
  logic        pause;
  logic [11:0] ball_center_col;
  logic        ball_load;
  logic [1:0]  serve_dir;
  logic        ball_run;
  logic [3:0]  l_score;
  logic [3:0]  r_score;
  logic [1:0]  winner;
  logic [2:0]  state;

  int n_cmp;
  int n_bad;

  pong_game_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .start           (start),
    .pause           (pause),
    .ball_center_col (ball_center_col),
    .ball_load       (ball_load),
    .serve_dir       (serve_dir),
    .ball_run        (ball_run),
    .l_score         (l_score),
    .r_score         (r_score),
    .winner          (winner),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driver tasks start and end at a negedge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; ball_center_col = 12'd400;
    step(3);
    rst_n = 1'b1;
    step(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (serve_dir !== 2'b01) begin n_bad++; $display("FAIL reset_dir got %b want 01", serve_dir); end
    n_cmp++; if ({ball_load, ball_run} !== 2'b00) begin n_bad++; $display("FAIL reset_ctl got %b want 00", {ball_load, ball_run}); end
    n_cmp++; if ({l_score, r_score, winner} !== 10'd0) begin n_bad++; $display("FAIL reset_score got %h want 0", {l_score, r_score, winner}); end
  endtask

  task automatic test_first_serve;
    start = 1'b1;
    step(1);
    n_cmp++; if ({state, ball_load, serve_dir} !== {3'd1, 1'b1, 2'b01}) begin n_bad++; $display("FAIL serve_enter got st=%0d ld=%b dir=%b want st=1 ld=1 dir=01", state, ball_load, serve_dir); end
    start = 1'b0;
    step(1);
    n_cmp++; if ({ball_load, ball_run} !== 2'b00) begin n_bad++; $display("FAIL serve_pulse got ld=%b run=%b want 0 0", ball_load, ball_run); end
    do_ticks(60);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_60 got %0d want 1", state); end
    do_ticks(1);
    n_cmp++; if ({state, ball_run, serve_dir} !== {3'd2, 1'b1, 2'b01}) begin n_bad++; $display("FAIL serve_61 got st=%0d run=%b dir=%b want 2 1 01", state, ball_run, serve_dir); end
  endtask

  task automatic test_left_miss_and_pause;
    ball_center_col = 12'd4;
    step(1);
    n_cmp++; if ({r_score, state, ball_run} !== {4'd1, 3'd3, 1'b0}) begin n_bad++; $display("FAIL left_miss got r=%0d st=%0d run=%b want 1 3 0", r_score, state, ball_run); end
    ball_center_col = 12'd400;
    do_ticks(30);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL point_30 got %0d want 3", state); end
    do_ticks(1);
    n_cmp++; if ({state, ball_load, serve_dir} !== {3'd1, 1'b1, 2'b00}) begin n_bad++; $display("FAIL point_31 got st=%0d ld=%b dir=%b want 1 1 00", state, ball_load, serve_dir); end
    pause = 1'b1;
    do_ticks(100);
    n_cmp++; if ({state, ball_run} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL serve_pause got st=%0d run=%b want 1 0", state, ball_run); end
    pause = 1'b0;
    do_ticks(60);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_frozen got %0d want 1", state); end
    do_ticks(1);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL serve_resume got %0d want 2", state); end
    pause = 1'b1;
    #1;
    n_cmp++; if (ball_run !== 1'b0) begin n_bad++; $display("FAIL play_pause_run got %b want 0", ball_run); end
    step(5);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL play_pause_state got %0d want 2", state); end
    pause = 1'b0;
    #1;
    n_cmp++; if (ball_run !== 1'b1) begin n_bad++; $display("FAIL play_unpause got %b want 1", ball_run); end
    step(1);
  endtask

  task automatic test_right_miss;
    ball_center_col = 12'd796;
    step(1);
    n_cmp++; if ({l_score, r_score, state} !== {4'd1, 4'd1, 3'd3}) begin n_bad++; $display("FAIL right_miss got l=%0d r=%0d st=%0d want 1 1 3", l_score, r_score, state); end
    ball_center_col = 12'd400;
    do_ticks(31);
    n_cmp++; if ({state, serve_dir} !== {3'd1, 2'b11}) begin n_bad++; $display("FAIL right_serve got st=%0d dir=%b want 1 11", state, serve_dir); end
    do_ticks(61);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL right_replay got %0d want 2", state); end
  endtask

  task automatic test_win_and_restart;
    for (int i = 2; i <= 11; i++) begin
      ball_center_col = 12'd3;
      step(1);
      ball_center_col = 12'd400;
      n_cmp++; if (r_score !== 4'(i)) begin n_bad++; $display("FAIL win_r_score got %0d want %0d", r_score, i); end
      do_ticks(31);
      if (i < 11) do_ticks(61);
    end
    n_cmp++; if ({state, winner, ball_run} !== {3'd4, 2'b10, 1'b0}) begin n_bad++; $display("FAIL game_over got st=%0d win=%b run=%b want 4 10 0", state, winner, ball_run); end
    ball_center_col = 12'd0;
    do_ticks(40);
    n_cmp++; if ({l_score, r_score, state} !== {4'd1, 4'd11, 3'd4}) begin n_bad++; $display("FAIL over_hold got l=%0d r=%0d st=%0d want 1 11 4", l_score, r_score, state); end
    ball_center_col = 12'd400;
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if ({l_score, r_score, winner, state, serve_dir, ball_load} !== {4'd0, 4'd0, 2'b00, 3'd1, 2'b01, 1'b1}) begin n_bad++; $display("FAIL restart got l=%0d r=%0d w=%b st=%0d dir=%b ld=%b want 0 0 00 1 01 1", l_score, r_score, winner, state, serve_dir, ball_load); end
    do_ticks(61);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin
      ball_center_col = 12'd800;
      step(1);
      ball_center_col = 12'd400;
      do_ticks(31);
      n_cmp++; if (serve_dir !== {1'b1, 1'(i)}) begin n_bad++; $display("FAIL toggle_dir got %b want %b", serve_dir, {1'b1, 1'(i)}); end
      do_ticks(61);
    end
    n_cmp++; if ({l_score, state} !== {4'd5, 3'd2}) begin n_bad++; $display("FAIL pre_reset got l=%0d st=%0d want 5 2", l_score, state); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({state, ball_load, serve_dir, ball_run, l_score, r_score, winner} !== {3'd0, 1'b0, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00}) begin
      n_bad++; $display("FAIL async_reset got st=%0d ld=%b dir=%b run=%b l=%0d r=%0d w=%b", state, ball_load, serve_dir, ball_run, l_score, r_score, winner);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL post_reset got %0d want 0", state); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_first_serve();
    test_left_miss_and_pause();
    test_right_miss();
    test_win_and_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
